cpu: RTL and testbench

Minimal 16-bit load/store processor core with a two-state fetch/execute sequencer and a 16×16 register file. It connects to a word-organised memory block (128 × 16, asynchronous read, synchronous write) through a single shared address/data port. Every instruction takes exactly two clock cycles.

---
 rtl/cpu.sv | 122 ++++++++++++
 tb/tb_cpu.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/cpu.sv
// Minimal 16-bit load/store core: two-cycle fetch/execute sequencer, 16x16 register file.
// Optional multiplier for opcode 0x8 enabled by defining CPU_MUL_EN.

module cpu_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  a_sel,
  input  logic [3:0]  b_sel,
  input  logic [3:0]  c_sel,
  output logic [15:0] a_data,
  output logic [15:0] b_data,
  output logic [15:0] c_data,
  input  logic        we,
  input  logic [3:0]  w_sel,
  input  logic [15:0] w_data
);
  logic [15:0] registers [0:15];

  // r0 is never written, so it stays at its reset value of zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) registers[i] <= '0;
    end else if (we && w_sel != 4'd0) begin
      registers[w_sel] <= w_data;
    end
  end

  assign a_data = registers[a_sel];
  assign b_data = registers[b_sel];
  assign c_data = registers[c_sel];
endmodule

module cpu (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] mem_out,
  output logic        mem_we,
  output logic [14:0] mem_addr,
  output logic [15:0] mem_in
);
  typedef enum logic {FETCH, EXECUTE} state_t;

  localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR  = 4'h3,
                         OP_XOR = 4'h4, OP_SHL = 4'h5, OP_SHR = 4'h6, OP_MUL = 4'h8,
                         OP_LUI = 4'hA, OP_LD  = 4'hC, OP_ST  = 4'hD, OP_BEQZ = 4'hE,
                         OP_LI  = 4'hF;

  state_t      state, state_nx;
  logic [15:0] pc, pc_nx, ir;
  logic [15:0] a_data, b_data, c_data, ea, wr_data;
  logic        wr_en, is_mem;

  wire [3:0] op   = ir[15:12];
  wire [3:0] fa   = ir[11:8];
  wire [3:0] fb   = ir[7:4];
  wire [3:0] fc   = ir[3:0];
  wire [7:0] imm8 = ir[7:0];

  cpu_regfile register_file (
    .clk    (clk),
    .rst    (rst),
    .a_sel  (fa),
    .b_sel  (fb),
    .c_sel  (fc),
    .a_data (a_data),
    .b_data (b_data),
    .c_data (c_data),
    .we     (wr_en),
    .w_sel  (fa),
    .w_data (wr_data)
  );

  assign ea       = b_data + {{11{fc[3]}}, fc, 1'b0};
  assign is_mem   = (state == EXECUTE) && (op == OP_LD || op == OP_ST);
  assign mem_addr = is_mem ? ea[15:1] : pc[15:1];
  assign mem_we   = (state == EXECUTE) && (op == OP_ST);
  assign mem_in   = a_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH;
      pc    <= '0;
      ir    <= '0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      if (state == FETCH) ir <= mem_out;
    end
  end

  always_comb begin
    state_nx = FETCH;
    pc_nx    = pc;
    wr_en    = 1'b0;
    wr_data  = '0;
    if (state == FETCH) begin
      state_nx = EXECUTE;
      pc_nx    = pc + 16'd2;
    end else begin
      // pc already points past this instruction when the branch offset is added
      if (op == OP_BEQZ && a_data == 16'd0)
        pc_nx = pc + {{7{imm8[7]}}, imm8, 1'b0};
      wr_en = 1'b1;
      case (op)
        OP_ADD: wr_data = b_data + c_data;
        OP_SUB: wr_data = b_data - c_data;
        OP_AND: wr_data = b_data & c_data;
        OP_OR:  wr_data = b_data | c_data;
        OP_XOR: wr_data = b_data ^ c_data;
        OP_SHL: wr_data = b_data << c_data[3:0];
        OP_SHR: wr_data = b_data >> c_data[3:0];
`ifdef CPU_MUL_EN
        OP_MUL: wr_data = b_data * c_data;
`endif
        OP_LUI: wr_data = {imm8, a_data[7:0]};
        OP_LD:  wr_data = mem_out;
        OP_LI:  wr_data = {8'h00, imm8};
        default: wr_en = 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu.sv
// Directed self-checking bench for cpu with a 128x16 async-read memory model.
`timescale 1ns/100ps
module tb_cpu;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] mem_out;
  logic        mem_we;
  logic [14:0] mem_addr;
  logic [15:0] mem_in;
  logic [15:0] mem [0:127];
  int checks = 0;
  int errors = 0;

  cpu dut (.clk(clk), .rst(rst), .mem_out(mem_out), .mem_we(mem_we),
           .mem_addr(mem_addr), .mem_in(mem_in));

  always #1 clk = ~clk;
  assign mem_out = mem[mem_addr[6:0]];
  always @(posedge clk) if (mem_we) mem[mem_addr[6:0]] <= mem_in;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic hold_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    hold_reset();
    tick(2);
    checks++; if (dut.pc !== 16'h0) begin errors++; $display("FAIL reset_pc got %h exp 0000", dut.pc); end
    checks++; if (dut.ir !== 16'h0) begin errors++; $display("FAIL reset_ir got %h exp 0000", dut.ir); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b exp 0", mem_we); end
    checks++; if (mem_addr !== 15'h0) begin errors++; $display("FAIL reset_addr got %h exp 0000", mem_addr); end
    checks++; if (mem_in !== 16'h0) begin errors++; $display("FAIL reset_in got %h exp 0000", mem_in); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (dut.register_file.registers[i] !== 16'h0) begin
        errors++; $display("FAIL reset_r%0d got %h exp 0000", i, dut.register_file.registers[i]);
      end
    end
  endtask

  task automatic test_basic();
    hold_reset();
    mem[0] = 16'hF10A; mem[1] = 16'hF20A; mem[2] = 16'hD120;
    release_reset();
    tick(2);
    checks++; if (dut.register_file.registers[1] !== 16'd10) begin errors++; $display("FAIL basic_r1 got %h exp 000a", dut.register_file.registers[1]); end
    tick(2);
    checks++; if (dut.register_file.registers[2] !== 16'd10) begin errors++; $display("FAIL basic_r2 got %h exp 000a", dut.register_file.registers[2]); end
    tick(1);
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL basic_st_we got %b exp 1", mem_we); end
    checks++; if (mem_addr !== 15'd5) begin errors++; $display("FAIL basic_st_addr got %h exp 0005", mem_addr); end
    checks++; if (mem_in !== 16'd10) begin errors++; $display("FAIL basic_st_data got %h exp 000a", mem_in); end
    tick(1);
    checks++; if (mem[5] !== 16'd10) begin errors++; $display("FAIL basic_mem5 got %h exp 000a", mem[5]); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL basic_we_low got %b exp 0", mem_we); end
  endtask

  task automatic test_alu();
    hold_reset();
    mem[0] = 16'hF10C; mem[1] = 16'hF205; mem[2] = 16'h1312; mem[3] = 16'h5412;
    mem[4] = 16'h0011; mem[5] = 16'h4612; mem[6] = 16'h2812; mem[7] = 16'h3912;
    mem[8] = 16'hFB02; mem[9] = 16'h6A1B; mem[10] = 16'h0111;
    release_reset();
    tick(22);
    checks++; if (dut.register_file.registers[3] !== 16'h0007) begin errors++; $display("FAIL alu_sub got %h exp 0007", dut.register_file.registers[3]); end
    checks++; if (dut.register_file.registers[4] !== 16'h0180) begin errors++; $display("FAIL alu_shl got %h exp 0180", dut.register_file.registers[4]); end
    checks++; if (dut.register_file.registers[0] !== 16'h0000) begin errors++; $display("FAIL alu_r0 got %h exp 0000", dut.register_file.registers[0]); end
    checks++; if (dut.register_file.registers[6] !== 16'h0009) begin errors++; $display("FAIL alu_xor got %h exp 0009", dut.register_file.registers[6]); end
    checks++; if (dut.register_file.registers[8] !== 16'h0004) begin errors++; $display("FAIL alu_and got %h exp 0004", dut.register_file.registers[8]); end
    checks++; if (dut.register_file.registers[9] !== 16'h000D) begin errors++; $display("FAIL alu_or got %h exp 000d", dut.register_file.registers[9]); end
    checks++; if (dut.register_file.registers[10] !== 16'h0003) begin errors++; $display("FAIL alu_shr got %h exp 0003", dut.register_file.registers[10]); end
    checks++; if (dut.register_file.registers[1] !== 16'h0018) begin errors++; $display("FAIL alu_self_add got %h exp 0018", dut.register_file.registers[1]); end
    checks++; if (dut.pc !== 16'd22) begin errors++; $display("FAIL alu_pc got %h exp 0016", dut.pc); end
  endtask

  task automatic test_load_lui();
    hold_reset();
    mem[0] = 16'hF20A; mem[1] = 16'hC521; mem[2] = 16'hA512; mem[3] = 16'hC62F;
    mem[4] = 16'h1234; mem[6] = 16'hBEEF;
    release_reset();
    tick(3);
    checks++; if (mem_addr !== 15'd6) begin errors++; $display("FAIL ld_addr got %h exp 0006", mem_addr); end
    tick(1);
    checks++; if (dut.register_file.registers[5] !== 16'hBEEF) begin errors++; $display("FAIL ld_r5 got %h exp beef", dut.register_file.registers[5]); end
    tick(2);
    checks++; if (dut.register_file.registers[5] !== 16'h12EF) begin errors++; $display("FAIL lui_r5 got %h exp 12ef", dut.register_file.registers[5]); end
    tick(2);
    checks++; if (dut.register_file.registers[6] !== 16'h1234) begin errors++; $display("FAIL ld_negoff got %h exp 1234", dut.register_file.registers[6]); end
  endtask

  task automatic test_beqz();
    hold_reset();
    mem[0] = 16'hE102; mem[3] = 16'hE0FE;
    release_reset();
    tick(2);
    checks++; if (dut.pc !== 16'd6) begin errors++; $display("FAIL beqz_taken_pc got %h exp 0006", dut.pc); end
    checks++; if (mem_addr !== 15'd3) begin errors++; $display("FAIL beqz_taken_addr got %h exp 0003", mem_addr); end
    tick(2);
    checks++; if (dut.pc !== 16'd4) begin errors++; $display("FAIL beqz_back_pc got %h exp 0004", dut.pc); end
    hold_reset();
    mem[0] = 16'hF101; mem[1] = 16'hE102;
    release_reset();
    tick(4);
    checks++; if (dut.pc !== 16'd4) begin errors++; $display("FAIL beqz_not_taken_pc got %h exp 0004", dut.pc); end
    checks++; if (mem_addr !== 15'd2) begin errors++; $display("FAIL beqz_not_taken_addr got %h exp 0002", mem_addr); end
  endtask

  task automatic test_pc_wrap();
    hold_reset();
    mem[0] = 16'hE0FE; mem[127] = 16'hF377;
    release_reset();
    tick(2);
    checks++; if (dut.pc !== 16'hFFFE) begin errors++; $display("FAIL wrap_pc_neg got %h exp fffe", dut.pc); end
    tick(1);
    checks++; if (dut.pc !== 16'h0000) begin errors++; $display("FAIL wrap_pc_zero got %h exp 0000", dut.pc); end
    tick(1);
    checks++; if (dut.register_file.registers[3] !== 16'h0077) begin errors++; $display("FAIL wrap_r3 got %h exp 0077", dut.register_file.registers[3]); end
  endtask

  task automatic test_reset_store();
    hold_reset();
    mem[0] = 16'hF133; mem[1] = 16'hF20A; mem[2] = 16'hD120; mem[5] = 16'h5555;
    release_reset();
    tick(5);
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL rst_st_pre_we got %b exp 1", mem_we); end
    rst = 1'b1;
    #0.2;
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_st_we got %b exp 0", mem_we); end
    checks++; if (dut.register_file.registers[1] !== 16'h0) begin errors++; $display("FAIL rst_st_r1 got %h exp 0000", dut.register_file.registers[1]); end
    checks++; if (dut.register_file.registers[2] !== 16'h0) begin errors++; $display("FAIL rst_st_r2 got %h exp 0000", dut.register_file.registers[2]); end
    tick(1);
    checks++; if (mem[5] !== 16'h5555) begin errors++; $display("FAIL rst_st_mem got %h exp 5555", mem[5]); end
    release_reset();
    #0.2;
    checks++; if (mem_addr !== 15'd0) begin errors++; $display("FAIL rst_st_addr got %h exp 0000", mem_addr); end
    checks++; if (dut.pc !== 16'd0) begin errors++; $display("FAIL rst_st_pc got %h exp 0000", dut.pc); end
    tick(2);
    checks++; if (dut.register_file.registers[1] !== 16'h0033) begin errors++; $display("FAIL rst_st_rerun got %h exp 0033", dut.register_file.registers[1]); end
  endtask

  task automatic test_mul();
    logic [15:0] exp_r3;
`ifdef CPU_MUL_EN
    exp_r3 = 16'h5F90;
`else
    exp_r3 = 16'h0055;
`endif
    hold_reset();
    mem[0] = 16'hF355; mem[1] = 16'hF12C; mem[2] = 16'hA101; mem[3] = 16'hF22C;
    mem[4] = 16'hA201; mem[5] = 16'h8312;
    release_reset();
    tick(10);
    checks++; if (dut.register_file.registers[1] !== 16'd300) begin errors++; $display("FAIL mul_r1 got %h exp 012c", dut.register_file.registers[1]); end
    tick(2);
    checks++; if (dut.register_file.registers[3] !== exp_r3) begin errors++; $display("FAIL mul_r3 got %h exp %h", dut.register_file.registers[3], exp_r3); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_alu();
    test_load_lui();
    test_beqz();
    test_pc_wrap();
    test_reset_store();
    test_mul();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
